// File: rtl/exception_arbiter_pkg.sv
// Shared cause codes, CP0 SR field positions, record/state types and the EPC helper
// for the exception arbiter.
package exception_arbiter_pkg;

  localparam int CAUSE_W = 5;

  localparam logic [CAUSE_W-1:0] CAUSE_INT  = 5'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ADEL = 5'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_ADES = 5'd5;
  localparam logic [CAUSE_W-1:0] CAUSE_RI   = 5'd10;
  localparam logic [CAUSE_W-1:0] CAUSE_OV   = 5'd12;
  localparam logic [CAUSE_W-1:0] CAUSE_ERET = 5'd31;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } arb_state_e;

  typedef struct packed {
    logic               valid;
    logic [CAUSE_W-1:0] cause;
  } exc_rec_t;

  // A delay-slot instruction reports the PC of its branch so the branch is re-executed.
  function automatic logic [31:0] epc_calc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exception_arbiter_if.sv
// Pipeline/CP0 signal bundle around the exception arbiter; master is the arbiter side.
interface exception_arbiter_if;
  logic        stall;
  logic        F_exc, D_exc, E_exc, M_exc;
  logic [4:0]  F_cause, D_cause, E_cause, M_cause;
  logic        M_valid;
  logic        M_eret;
  logic [31:0] M_pc;
  logic        M_bd;
  logic [5:0]  hwInt;
  logic [31:0] cp0_sr;
  logic        isException;
  logic [4:0]  exceptionCause;
  logic [31:0] exceptionPC;
  logic        exceptionBD;
  logic        flush;

  modport master (
    input  stall,
    input  F_exc, D_exc, E_exc, M_exc,
    input  F_cause, D_cause, E_cause, M_cause,
    input  M_valid, M_eret, M_pc, M_bd,
    input  hwInt, cp0_sr,
    output isException, exceptionCause, exceptionPC, exceptionBD, flush
  );

  modport slave (
    output stall,
    output F_exc, D_exc, E_exc, M_exc,
    output F_cause, D_cause, E_cause, M_cause,
    output M_valid, M_eret, M_pc, M_bd,
    output hwInt, cp0_sr,
    input  isException, exceptionCause, exceptionPC, exceptionBD, flush
  );
endinterface

// File: rtl/exception_arbiter_int_sync.sv
// Multi-flop synchronizer bringing the asynchronous hardware interrupt lines into clk.
module exception_arbiter_int_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exception_arbiter.sv
// Carries the oldest exception per instruction down to M, merges interrupts and ERET,
// and commits at most one event per flush window to CP0.
module exception_arbiter
  import exception_arbiter_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int SYNC_STAGES  = 2
) (
  input logic                 clk,
  input logic                 reset,
  exception_arbiter_if.master bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  exc_rec_t           d_rec_q, e_rec_q, m_rec_q;
  exc_rec_t           d_rec_d, e_rec_d, m_rec_d;
  exc_rec_t           m_cand;
  logic [5:0]         hw_sync;
  logic               int_pend;
  logic               commit;
  logic               isexc_q, isexc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [31:0]        pc_q, pc_d;
  logic               bd_q, bd_d;

  exception_arbiter_int_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (6)
  ) u_int_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.hwInt),
    .sync_o  (hw_sync)
  );

  assign int_pend = (|(hw_sync & bus.cp0_sr[SR_IM_HI:SR_IM_LO]))
                    & bus.cp0_sr[SR_IE] & ~bus.cp0_sr[SR_EXL];

  assign m_cand = m_rec_q.valid ? m_rec_q : '{valid: bus.M_exc, cause: bus.M_cause};

  // Record pipeline: an older record always overrides a newer detection for the same instruction.
  always_comb begin
    d_rec_d = d_rec_q;
    e_rec_d = e_rec_q;
    m_rec_d = m_rec_q;
    if (commit || (state_q == ST_FLUSH)) begin
      d_rec_d.valid = 1'b0;
      e_rec_d.valid = 1'b0;
      m_rec_d.valid = 1'b0;
    end else if (!bus.stall) begin
      d_rec_d = '{valid: bus.F_exc, cause: bus.F_cause};
      e_rec_d = d_rec_q.valid ? d_rec_q : '{valid: bus.D_exc, cause: bus.D_cause};
      m_rec_d = e_rec_q.valid ? e_rec_q : '{valid: bus.E_exc, cause: bus.E_cause};
    end
  end

  always_ff @(posedge clk) begin
    d_rec_q <= d_rec_d;
    e_rec_q <= e_rec_d;
    m_rec_q <= m_rec_d;
    if (reset) begin
      d_rec_q.valid <= 1'b0;
      e_rec_q.valid <= 1'b0;
      m_rec_q.valid <= 1'b0;
    end
  end

  // Commit decision and flush window; stall is deliberately not consulted here.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    cause_d = cause_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.M_valid && (int_pend || m_cand.valid || bus.M_eret)) begin
          commit  = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
          if (int_pend) begin
            cause_d = CAUSE_INT;
            pc_d    = epc_calc(bus.M_pc, bus.M_bd);
            bd_d    = bus.M_bd;
          end else if (m_cand.valid) begin
            cause_d = m_cand.cause;
            pc_d    = epc_calc(bus.M_pc, bus.M_bd);
            bd_d    = bus.M_bd;
          end else begin
            cause_d = CAUSE_ERET;
            pc_d    = bus.M_pc;
            bd_d    = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    isexc_d = commit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      isexc_q <= 1'b0;
      cause_q <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isexc_q <= isexc_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
    end
  end

  assign bus.isException    = isexc_q;
  assign bus.exceptionCause = cause_q;
  assign bus.exceptionPC    = pc_q;
  assign bus.exceptionBD    = bd_q;
  assign bus.flush          = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_exception_arbiter.sv
// Directed bench for exception_arbiter: record pipeline, priorities, interrupts, flush, reset, stall.
module tb_exception_arbiter;
  import exception_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  exception_arbiter_if bus();

  exception_arbiter #(
    .FLUSH_CYCLES (1),
    .SYNC_STAGES  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall   = 1'b0;
    bus.F_exc   = 1'b0; bus.D_exc = 1'b0; bus.E_exc = 1'b0; bus.M_exc = 1'b0;
    bus.F_cause = '0;   bus.D_cause = '0; bus.E_cause = '0; bus.M_cause = '0;
    bus.M_valid = 1'b0;
    bus.M_eret  = 1'b0;
    bus.M_pc    = '0;
    bus.M_bd    = 1'b0;
    bus.hwInt   = '0;
    bus.cp0_sr  = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_isexc", 32'(bus.isException), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_cause", 32'(bus.exceptionCause), 32'd0);
    chk("rst_pc", bus.exceptionPC, 32'd0);
    chk("rst_bd", 32'(bus.exceptionBD), 32'd0);

    // Test 1: D-stage RI travels to M in two cycles, commits when M is valid
    bus.D_exc = 1'b1; bus.D_cause = 5'd10;
    tick();
    bus.D_exc = 1'b0; bus.D_cause = '0;
    tick();
    chk("t1_no_early", 32'(bus.isException), 32'd0);
    bus.M_valid = 1'b1; bus.M_pc = 32'h3000; bus.M_bd = 1'b0;
    tick();
    chk("t1_isexc", 32'(bus.isException), 32'd1);
    chk("t1_cause", 32'(bus.exceptionCause), 32'd10);
    chk("t1_pc", bus.exceptionPC, 32'h3000);
    chk("t1_bd", 32'(bus.exceptionBD), 32'd0);
    chk("t1_flush", 32'(bus.flush), 32'd1);
    bus.M_valid = 1'b0;
    tick();
    chk("t1_pulse_end", 32'(bus.isException), 32'd0);
    chk("t1_flush_end", 32'(bus.flush), 32'd0);
    chk("t1_cause_hold", 32'(bus.exceptionCause), 32'd10);

    // Test 2: M-stage overflow in a delay slot
    bus.M_exc = 1'b1; bus.M_cause = 5'd12; bus.M_valid = 1'b1;
    bus.M_pc = 32'h3008; bus.M_bd = 1'b1;
    tick();
    chk("t2_isexc", 32'(bus.isException), 32'd1);
    chk("t2_cause", 32'(bus.exceptionCause), 32'd12);
    chk("t2_pc", bus.exceptionPC, 32'h3004);
    chk("t2_bd", 32'(bus.exceptionBD), 32'd1);
    idle_inputs();
    tick();
    chk("t2_pulse_end", 32'(bus.isException), 32'd0);

    // Test 3: interrupt through the synchronizer, then masked by EXL
    bus.cp0_sr = 32'h0000_FC01;
    bus.M_valid = 1'b1; bus.M_pc = 32'h5000; bus.M_bd = 1'b0;
    bus.hwInt = 6'b000100;
    tick();
    chk("t3_sync1", 32'(bus.isException), 32'd0);
    tick();
    chk("t3_sync2", 32'(bus.isException), 32'd0);
    tick();
    chk("t3_isexc", 32'(bus.isException), 32'd1);
    chk("t3_cause", 32'(bus.exceptionCause), 32'd0);
    chk("t3_pc", bus.exceptionPC, 32'h5000);
    bus.cp0_sr = 32'h0000_FC03;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_exl_masked", 32'(bus.isException), 32'd0);
    end
    idle_inputs();
    tick(); tick(); tick();

    // Test 4: older E exception wins, younger F exception is flushed
    bus.E_exc = 1'b1; bus.E_cause = 5'd4;
    bus.F_exc = 1'b1; bus.F_cause = 5'd5;
    tick();
    bus.E_exc = 1'b0; bus.F_exc = 1'b0;
    bus.M_valid = 1'b1; bus.M_pc = 32'h6000;
    tick();
    chk("t4_isexc", 32'(bus.isException), 32'd1);
    chk("t4_cause", 32'(bus.exceptionCause), 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_second", 32'(bus.isException), 32'd0);
    end
    chk("t4_cause_hold", 32'(bus.exceptionCause), 32'd4);
    idle_inputs();
    tick();

    // Test 5: ERET, then ERET losing to a pending interrupt
    bus.M_eret = 1'b1; bus.M_valid = 1'b1; bus.M_pc = 32'h4180; bus.M_bd = 1'b1;
    tick();
    chk("t5_isexc", 32'(bus.isException), 32'd1);
    chk("t5_cause", 32'(bus.exceptionCause), 32'(CAUSE_ERET));
    chk("t5_pc", bus.exceptionPC, 32'h4180);
    chk("t5_bd", 32'(bus.exceptionBD), 32'd0);
    chk("t5_flush", 32'(bus.flush), 32'd1);
    idle_inputs();
    bus.cp0_sr = 32'h0000_FC01; bus.hwInt = 6'b000001;
    tick();
    tick();
    chk("t5_int_waits", 32'(bus.isException), 32'd0);
    tick();
    chk("t5_int_no_valid", 32'(bus.isException), 32'd0);
    bus.M_eret = 1'b1; bus.M_valid = 1'b1; bus.M_pc = 32'h4180; bus.M_bd = 1'b0;
    tick();
    chk("t5_int_isexc", 32'(bus.isException), 32'd1);
    chk("t5_int_cause", 32'(bus.exceptionCause), 32'd0);
    idle_inputs();
    tick(); tick(); tick();

    // Test 6a: reset while flushing
    bus.M_exc = 1'b1; bus.M_cause = 5'd12; bus.M_valid = 1'b1; bus.M_pc = 32'h7000;
    tick();
    chk("t6_pre_flush", 32'(bus.flush), 32'd1);
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_isexc", 32'(bus.isException), 32'd0);
    chk("t6_rst_flush", 32'(bus.flush), 32'd0);
    chk("t6_rst_cause", 32'(bus.exceptionCause), 32'd0);
    chk("t6_rst_pc", bus.exceptionPC, 32'd0);
    chk("t6_rst_bd", 32'(bus.exceptionBD), 32'd0);

    // Test 6b: stall holds the record short of M
    bus.D_exc = 1'b1; bus.D_cause = 5'd10;
    tick();
    bus.D_exc = 1'b0; bus.stall = 1'b1;
    bus.M_valid = 1'b1; bus.M_pc = 32'h8000;
    tick();
    chk("t6_stall_hold1", 32'(bus.isException), 32'd0);
    tick();
    chk("t6_stall_hold2", 32'(bus.isException), 32'd0);
    bus.stall = 1'b0;
    tick();
    chk("t6_arrive_m", 32'(bus.isException), 32'd0);
    tick();
    chk("t6_isexc", 32'(bus.isException), 32'd1);
    chk("t6_cause", 32'(bus.exceptionCause), 32'd10);
    chk("t6_pc", bus.exceptionPC, 32'h8000);

    // Stall does not block an M commit; first cycle is the flush window
    bus.stall = 1'b1; bus.M_exc = 1'b1; bus.M_cause = 5'd5; bus.M_pc = 32'h9000;
    tick();
    chk("t6_flush_inhibit", 32'(bus.isException), 32'd0);
    tick();
    chk("t6_stall_commit", 32'(bus.isException), 32'd1);
    chk("t6_stall_cause", 32'(bus.exceptionCause), 32'd5);
    chk("t6_stall_pc", bus.exceptionPC, 32'h9000);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
